// File: rtl/popcnt_pkg.sv
// Purpose: shared types and width helper for the popcount stage, window sum and bench.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package popcnt_pkg;

  typedef enum logic {
    FILL = 1'b0,  // fewer than WIN_LEN samples held
    RUN  = 1'b1   // window full, every accept slides it
  } win_state_t;

  // Sum width for a window of 'win' counts, each up to 'width':
  // count width ($clog2(width)+2) plus enough bits for 'win' of them.
  function automatic int sum_width(input int width, input int win);
    return $clog2(width) + 2 + $clog2(win);
  endfunction

endpackage

// File: rtl/popcount_window_ring.sv
// Purpose: WIN_LEN x CNT_W circular store; exposes the entry about to be overwritten.
// Latency: oldest_o is combinational from the write pointer; writes land on the edge.
// Backpressure: none, a write is taken whenever wr_i is high.
// Ports: clk_i/arstn_i clock and async active-low reset, clr_i rewinds the pointer,
//        wr_i/dat_i store a count, oldest_o is the slot at the write pointer.
module popcount_window_ring #(
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = 7
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] dat_i,
  output logic [CNT_W-1:0] oldest_o
);

  localparam int PTR_W = $clog2(WIN_LEN);

  logic [CNT_W-1:0] mem_q [WIN_LEN];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // The slot at the write pointer holds the oldest sample once the window is
  // full; it is read here before the write on the same edge replaces it.
  assign oldest_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (wr_i) begin
      // Explicit wrap so non-power-of-two windows work.
      ptr_d = (ptr_q == PTR_W'(WIN_LEN - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is deliberately not reset: the FILL phase never reads stale slots.
  always_ff @(posedge clk_i) begin
    if (wr_i && !clr_i) begin
      mem_q[ptr_q] <= dat_i;
    end
  end

endmodule

// File: rtl/popcount_window_sum.sv
// Purpose: sliding-window sum of the last WIN_LEN accepted popcounts with threshold flag.
// Latency: sum_o/above_o/sum_val_o registered, updated on the edge that accepts a sample.
// Backpressure: none; cnt_val_i low is a bubble, clear_i drops a simultaneous sample.
// Ports: clk_i, arstn_i (async active low), cnt_i/cnt_val_i upstream count, clear_i flush,
//        thresh_i compare level, sum_o/above_o results qualified by sum_val_o pulse.
module popcount_window_sum
  import popcnt_pkg::*;
#(
  parameter int WIDTH   = 26,
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = $clog2(WIDTH) + 2,
  parameter int SUM_W   = sum_width(WIDTH, WIN_LEN)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cnt_val_i,
  input  logic             clear_i,
  input  logic [SUM_W-1:0] thresh_i,
  output logic [SUM_W-1:0] sum_o,
  output logic             sum_val_o,
  output logic             above_o
);

  localparam int FILL_W = $clog2(WIN_LEN + 1);

  win_state_t       state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             above_q, above_d;
  logic             val_q, val_d;
  logic [CNT_W-1:0] oldest;
  logic             accept;

  assign accept = cnt_val_i & ~clear_i;

  popcount_window_ring #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) u_ring (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .clr_i    (clear_i),
    .wr_i     (accept),
    .dat_i    (cnt_i),
    .oldest_o (oldest)
  );

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    above_d = above_q;
    val_d   = 1'b0;
    if (clear_i) begin
      state_d = FILL;
      fill_d  = '0;
      acc_d   = '0;
    end else if (cnt_val_i) begin
      case (state_q)
        FILL: begin
          acc_d = acc_q + SUM_W'(cnt_i);
          if (fill_q == FILL_W'(WIN_LEN - 1)) begin
            state_d = RUN;
            fill_d  = FILL_W'(WIN_LEN);
            val_d   = 1'b1;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        RUN: begin
          // acc always includes oldest here, so the subtraction cannot underflow.
          acc_d = acc_q + SUM_W'(cnt_i) - SUM_W'(oldest);
          val_d = 1'b1;
        end
        default: state_d = FILL;
      endcase
      if (val_d) begin
        sum_d   = acc_d;
        above_d = (acc_d > thresh_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= FILL;
      fill_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      above_q <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      above_q <= above_d;
      val_q   <= val_d;
    end
  end

  assign sum_o     = sum_q;
  assign above_o   = above_q;
  assign sum_val_o = val_q;

endmodule
